// File: rtl/pc_pkg.sv
// Shared constants and types for the PC fetch queue: reset/break addresses,
// fetch FSM states and the layout of one queued entry.
package pc_pkg;

  localparam logic [31:0] PC_INITIAL = 32'hbfc00000;
  localparam logic [31:0] PC_BREAK   = 32'hbfc00380;
  localparam int          ENTRY_W    = 65;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        excp;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_queue_if.sv
// Cache request/response bus plus the instruction output stream of the
// fetch queue; master is the fetch queue, slave is the cache/consumer side.
interface pc_fetch_queue_if;

  logic        cache_req;
  logic [31:0] cache_addr;
  logic        cache_ready;
  logic [31:0] cache_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_excp;

  modport master (
    output cache_req, cache_addr, out_valid, out_pc, out_instr, out_excp,
    input  cache_ready, cache_rdata, out_ready
  );

  modport slave (
    input  cache_req, cache_addr, out_valid, out_pc, out_instr, out_excp,
    output cache_ready, cache_rdata, out_ready
  );

endinterface

// File: rtl/pc_fetch_fifo.sv
// Circular FIFO holding fetched entries; flush empties it in one cycle.
module pc_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  import pc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush && (cnt != CW'(DEPTH));
  assign do_pop  = pop && !flush && (cnt != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign valid     = (cnt != '0);
  assign count     = cnt;

endmodule

// File: rtl/pc_fetch_queue.sv
// Instruction fetch front end: one outstanding cache request, queued results.
// Optional macro PC_FETCH_ALIGN_CHECK_EN turns misaligned PCs into fault entries.
module pc_fetch_queue #(
  parameter logic [31:0] PC_INITIAL = pc_pkg::PC_INITIAL,
  parameter logic [31:0] PC_BREAK   = pc_pkg::PC_BREAK,
  parameter int          QDEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      redir_valid,
  input  logic                      redir_excp,
  input  logic [31:0]               redir_target,
  pc_fetch_queue_if.master          bus,
  output logic [$clog2(QDEPTH):0]   occupancy
);
  import pc_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic [31:0]  redir_pc;
  logic         has_space;
  logic         align_fault;
  logic         stalled;
  logic         issue;
  logic         push;
  logic         fault_push;
  logic         pop;
  logic         flush;
  logic         head_valid;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign align_fault = (fetch_pc[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  assign redir_pc  = redir_excp ? PC_BREAK : redir_target;
  assign has_space = (occupancy < CW'(QDEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Redirects suppress issue and pushes; a response racing a redirect is dropped.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    fault_push = 1'b0;
    case (state)
      IDLE: begin
        if (!redir_valid && enable && has_space && !stalled) begin
          if (align_fault) begin
            fault_push = 1'b1;
          end else begin
            issue      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (redir_valid) begin
          state_next = bus.cache_ready ? IDLE : KILL;
        end else if (bus.cache_ready) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      KILL: begin
        if (bus.cache_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push_entry.excp  = fault_push;
    push_entry.pc    = fault_push ? fetch_pc : req_pc;
    push_entry.instr = fault_push ? 32'h0 : bus.cache_rdata;
  end

  // The issued address is latched so it stays stable even if KILL retargets fetch_pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= PC_INITIAL;
      req_pc   <= PC_INITIAL;
      stalled  <= 1'b0;
    end else if (redir_valid) begin
      fetch_pc <= redir_pc;
      stalled  <= 1'b0;
    end else begin
      if (issue)      req_pc   <= fetch_pc;
      if (push)       fetch_pc <= fetch_pc + 32'd4;
      if (fault_push) stalled  <= 1'b1;
    end
  end

  assign flush = redir_valid && (state != KILL);
  assign pop   = head_valid && bus.out_ready && enable && !redir_valid;

  pc_fetch_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push || fault_push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .valid     (head_valid),
    .count     (occupancy)
  );

  assign bus.cache_req  = issue || (state != IDLE);
  assign bus.cache_addr = (state == IDLE) ? fetch_pc : req_pc;
  assign bus.out_valid  = head_valid;
  assign bus.out_pc     = head_entry.pc;
  assign bus.out_instr  = head_entry.instr;
  assign bus.out_excp   = head_valid && head_entry.excp;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed bench for pc_fetch_queue with a scoreboard of expected queue entries.
module tb_pc_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        redir_valid;
  logic        redir_excp;
  logic [31:0] redir_target;
  logic [2:0]  occupancy;

  pc_fetch_queue_if bus();

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  int          checks = 0;
  int          passes = 0;

  pc_fetch_queue #(.QDEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .redir_valid  (redir_valid),
    .redir_excp   (redir_excp),
    .redir_target (redir_target),
    .bus          (bus),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passes++;
    else $error("[TB] FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic check_occ(input string tag, input int exp);
    check32(tag, {29'd0, occupancy}, exp[31:0]);
  endtask

  // Compare the queue head with the scoreboard front; consume it when popping.
  task automatic check_head(input string tag, input bit do_pop);
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) passes++;
    else $error("[TB] FAIL %s_sb: got empty scoreboard expected entry", tag);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      if (do_pop) void'(exp_q.pop_front());
      check1({tag, "_valid"}, bus.out_valid, 1'b1);
      check32({tag, "_pc"}, bus.out_pc, e.pc);
      check32({tag, "_instr"}, bus.out_instr, e.instr);
    end
  endtask

  // Request seen now, answered one cycle later.
  task automatic serve(input logic [31:0] data);
    check1("serve_req", bus.cache_req, 1'b1);
    check32("serve_addr", bus.cache_addr, model_pc);
    tick();
    bus.cache_ready = 1'b1;
    bus.cache_rdata = data;
    #1;
    check1("serve_req_hold", bus.cache_req, 1'b1);
    check32("serve_addr_hold", bus.cache_addr, model_pc);
    exp_q.push_back({model_pc, data});
    model_pc = model_pc + 32'd4;
    tick();
    bus.cache_ready = 1'b0;
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b0;
    redir_valid     = 1'b0;
    redir_excp      = 1'b0;
    redir_target    = 32'h0;
    bus.cache_ready = 1'b0;
    bus.cache_rdata = 32'h0;
    bus.out_ready   = 1'b0;
    model_pc        = 32'hbfc00000;

    // Reset state
    tick();
    tick();
    check1("rst_req", bus.cache_req, 1'b0);
    check32("rst_addr", bus.cache_addr, 32'hbfc00000);
    check1("rst_valid", bus.out_valid, 1'b0);
    check1("rst_excp", bus.out_excp, 1'b0);
    check_occ("rst_occ", 0);

    // Fill the queue with out_ready low
    reset  = 1'b0;
    tick();
    enable = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) serve($urandom);
    for (int i = 0; i < 3; i++) begin
      check1("full_req", bus.cache_req, 1'b0);
      check_occ("full_occ", 4);
      tick();
    end

    // One pop frees space for the next request
    bus.out_ready = 1'b1;
    #1;
    check_head("pop1", 1'b1);
    tick();
    bus.out_ready = 1'b0;
    #1;
    check_occ("after_pop_occ", 3);
    serve($urandom);
    check_occ("refill_occ", 4);
    check1("refill_req", bus.cache_req, 1'b0);

    // Drain three; the freed space lets a request go out and stay pending
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_head("drain", 1'b1);
      tick();
    end
    bus.out_ready = 1'b0;
    #1;
    check_occ("drain_occ", 1);
    check1("pend_req", bus.cache_req, 1'b1);
    check32("pend_addr", bus.cache_addr, 32'hbfc00014);

    // Redirect while a request is pending
    redir_valid  = 1'b1;
    redir_target = 32'h80001000;
    #1;
    check32("redir_addr_hold", bus.cache_addr, 32'hbfc00014);
    tick();
    redir_valid = 1'b0;
    exp_q.delete();
    model_pc = 32'h80001000;
    #1;
    check1("kill_valid", bus.out_valid, 1'b0);
    check_occ("kill_occ", 0);
    check1("kill_req", bus.cache_req, 1'b1);
    check32("kill_addr", bus.cache_addr, 32'hbfc00014);
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'hdeadbeef;
    tick();
    bus.cache_ready = 1'b0;
    #1;
    check_occ("late_drop_occ", 0);
    check1("late_drop_valid", bus.out_valid, 1'b0);
    check1("post_kill_req", bus.cache_req, 1'b1);
    check32("post_kill_addr", bus.cache_addr, 32'h80001000);

    // Push and pop in the same cycle
    serve(32'h11111111);
    check_head("peek", 1'b0);
    check32("next_addr", bus.cache_addr, model_pc);
    tick();
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'h22222222;
    bus.out_ready   = 1'b1;
    #1;
    check_occ("pp_before", 1);
    check_head("pp_pop", 1'b1);
    exp_q.push_back({model_pc, 32'h22222222});
    model_pc = model_pc + 32'd4;
    tick();
    bus.cache_ready = 1'b0;
    bus.out_ready   = 1'b0;
    #1;
    check_occ("pp_after", 1);
    check_head("pp_head", 1'b0);

    // Exception redirect coinciding with cache_ready
    check32("pre_excp_addr", bus.cache_addr, 32'h80001008);
    tick();
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'h33333333;
    redir_valid     = 1'b1;
    redir_excp      = 1'b1;
    redir_target    = 32'h12345678;
    tick();
    bus.cache_ready = 1'b0;
    redir_valid     = 1'b0;
    redir_excp      = 1'b0;
    exp_q.delete();
    model_pc = 32'hbfc00380;
    #1;
    check_occ("excp_occ", 0);
    check1("excp_valid", bus.out_valid, 1'b0);
    check1("excp_req", bus.cache_req, 1'b1);
    check32("excp_addr", bus.cache_addr, 32'hbfc00380);

    // enable low while a request is pending
    tick();
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check1("en0_req", bus.cache_req, 1'b1);
    check32("en0_addr", bus.cache_addr, 32'hbfc00380);
    tick();
    tick();
    check1("en0_req_hold", bus.cache_req, 1'b1);
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'h44444444;
    exp_q.push_back({model_pc, 32'h44444444});
    model_pc = model_pc + 32'd4;
    tick();
    bus.cache_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_occ("en0_occ", 1);
      check1("en0_no_req", bus.cache_req, 1'b0);
      tick();
    end
    enable = 1'b1;
    #1;
    check1("en1_req", bus.cache_req, 1'b1);
    check32("en1_addr", bus.cache_addr, 32'hbfc00384);
    check_head("en1_pop", 1'b1);
    tick();
    check_occ("en1_occ", 0);
    bus.out_ready = 1'b0;

    // Reset in the middle of a request; a later response is ignored
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    check1("midrst_req", bus.cache_req, 1'b0);
    check32("midrst_addr", bus.cache_addr, 32'hbfc00000);
    check_occ("midrst_occ", 0);
    tick();
    reset = 1'b0;
    tick();
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'h55555555;
    tick();
    bus.cache_ready = 1'b0;
    #1;
    check_occ("idle_resp_occ", 0);
    check1("idle_resp_valid", bus.out_valid, 1'b0);
    exp_q.delete();
    model_pc = 32'hbfc00000;
    enable   = 1'b1;
    #1;
    serve(32'h66666666);
    check_head("after_rst", 1'b0);

`ifdef PC_FETCH_ALIGN_CHECK_EN
    // Misaligned redirect produces a fault entry and stalls fetch
    enable       = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h80000002;
    tick();
    redir_valid = 1'b0;
    enable      = 1'b1;
    #1;
    check1("align_no_req", bus.cache_req, 1'b0);
    tick();
    check1("align_valid", bus.out_valid, 1'b1);
    check1("align_excp", bus.out_excp, 1'b1);
    check32("align_pc", bus.out_pc, 32'h80000002);
    check32("align_instr", bus.out_instr, 32'h0);
    tick();
    tick();
    check1("align_stall_req", bus.cache_req, 1'b0);
    check_occ("align_occ", 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
